// File: rtl/conv1_mem_rd.sv
// conv1_mem_rd: read-side address sequencer for the conv1 output feature map.
// Walks the map in 2x2 max-pool window order, one read per cycle when the pool
// unit is ready, and tags returning data with window position and pool index.
module conv1_mem_rd #(
   parameter int unsigned MAP_W  = 24,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned BASE   = 0,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned POOL_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              ready,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   output logic              dv,
   output logic [1:0]        win_pos,
   output logic              win_first,
   output logic              win_last,
   output logic [POOL_W-1:0] pool_addr,
   output logic              busy,
   output logic              done
);

   localparam int unsigned HALF = MAP_W / 2;
   localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) + 1 : 1;
   localparam int unsigned LW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(HALF - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_issue;
   logic                w_clear;
   logic                w_last_elem;
   logic                w_drain_end;

   logic [CW-1:0]       r_wr;
   logic [CW-1:0]       r_wc;
   logic [1:0]          r_pos;
   logic [ADDR_W-1:0]   r_row_base;
   logic [ADDR_W-1:0]   r_col_base;
   logic [POOL_W-1:0]   r_pool;
   logic [LW-1:0]       r_drain_cnt;
   logic                r_busy;
   logic                r_done;

   logic [ADDR_W-1:0]   w_row;
   logic [ADDR_W-1:0]   w_addr;

   logic                r_tv    [RD_LAT];
   logic [1:0]          r_tpos  [RD_LAT];
   logic [POOL_W-1:0]   r_tpool [RD_LAT];

   assign w_last_elem = (r_wr == LAST_IDX) && (r_wc == LAST_IDX) && (r_pos == 2'd3);
   assign w_drain_end = (r_drain_cnt == LW'(RD_LAT - 1));

   // Next-state and issue decode
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = ISSUE;
               w_clear     = 1'b1;
            end
         end
         ISSUE: begin
            if (ready) begin
               w_issue = 1'b1;
               if (w_last_elem) begin
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (w_drain_end) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               w_state_nxt = ISSUE;
               w_clear     = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register plus registered busy/done flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN);
         r_done  <= (w_state_nxt == DONE);
      end
   end

   // Window walk counters; row/column bases track addresses without a multiplier
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr       <= '0;
         r_wc       <= '0;
         r_pos      <= '0;
         r_row_base <= '0;
         r_col_base <= '0;
         r_pool     <= '0;
      end else if (w_clear) begin
         r_wr       <= '0;
         r_wc       <= '0;
         r_pos      <= '0;
         r_row_base <= '0;
         r_col_base <= '0;
         r_pool     <= '0;
      end else if (w_issue) begin
         r_pos <= r_pos + 2'd1;
         if (r_pos == 2'd3) begin
            r_pool <= r_pool + POOL_W'(1);
            if (r_wc == LAST_IDX) begin
               r_wc       <= '0;
               r_col_base <= '0;
               r_wr       <= r_wr + CW'(1);
               r_row_base <= r_row_base + ADDR_W'(2 * MAP_W);
            end else begin
               r_wc       <= r_wc + CW'(1);
               r_col_base <= r_col_base + ADDR_W'(2);
            end
         end
      end
   end

   // Counts cycles spent draining so DONE lands as the last tag leaves
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_drain_cnt <= '0;
      end else if (r_state != DRAIN) begin
         r_drain_cnt <= '0;
      end else begin
         r_drain_cnt <= r_drain_cnt + LW'(1);
      end
   end

   // Tag pipeline matching the RAM read latency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            r_tv[i]    <= 1'b0;
            r_tpos[i]  <= '0;
            r_tpool[i] <= '0;
         end
      end else begin
         r_tv[0]    <= w_issue;
         r_tpos[0]  <= w_issue ? r_pos : 2'd0;
         r_tpool[0] <= w_issue ? r_pool : '0;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            r_tv[i]    <= r_tv[i-1];
            r_tpos[i]  <= r_tpos[i-1];
            r_tpool[i] <= r_tpool[i-1];
         end
      end
   end

   // Read address from the registered counters; forced to zero outside ISSUE
   assign w_row  = r_row_base + (r_pos[1] ? ADDR_W'(MAP_W) : '0);
   assign w_addr = ADDR_W'(BASE) + w_row + r_col_base + ADDR_W'(r_pos[0]);

   assign rd_addr   = (r_state == ISSUE) ? w_addr : '0;
   assign rd_en     = w_issue;
   assign dv        = r_tv[RD_LAT-1];
   assign win_pos   = r_tpos[RD_LAT-1];
   assign pool_addr = r_tpool[RD_LAT-1];
   assign win_first = r_tv[RD_LAT-1] && (r_tpos[RD_LAT-1] == 2'd0);
   assign win_last  = r_tv[RD_LAT-1] && (r_tpos[RD_LAT-1] == 2'd3);
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_conv1_mem_rd.sv
// tb_conv1_mem_rd: bench for the conv1 read sequencer; one instance at RD_LAT=1/BASE=0,
// one at RD_LAT=3/BASE=144, checked against a window-order address model.
module tb_conv1_mem_rd;

   typedef struct {
      int idx;
      int addr;
      int pos;
      int pool;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b;
   logic       ready;

   logic [9:0] a_rd_addr, b_rd_addr;
   logic       a_rd_en, b_rd_en, a_dv, b_dv;
   logic [1:0] a_win_pos, b_win_pos;
   logic       a_first, b_first, a_last, b_last;
   logic [7:0] a_pool, b_pool;
   logic       a_busy, b_busy, a_done, b_done;

   logic [9:0] m_rd_addr;
   logic       m_rd_en, m_dv, m_first, m_last, m_busy, m_done;
   logic [1:0] m_win_pos;
   logic [7:0] m_pool;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   int  t0      = 0;
   int  done_cyc;
   bit  sel;
   bit  mon;
   bit  rand_ready;

   int  rd_addr_q[$];
   int  rd_cyc_q[$];
   int  dv_pos_q[$];
   int  dv_pool_q[$];
   int  dv_first_q[$];
   int  dv_last_q[$];
   int  dv_cyc_q[$];

   vec_t tbl[16];

   conv1_mem_rd #(.MAP_W(24), .ADDR_W(10), .BASE(0), .RD_LAT(1), .POOL_W(8)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .ready(ready),
      .rd_addr(a_rd_addr), .rd_en(a_rd_en), .dv(a_dv), .win_pos(a_win_pos),
      .win_first(a_first), .win_last(a_last), .pool_addr(a_pool),
      .busy(a_busy), .done(a_done)
   );

   conv1_mem_rd #(.MAP_W(24), .ADDR_W(10), .BASE(144), .RD_LAT(3), .POOL_W(8)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .ready(ready),
      .rd_addr(b_rd_addr), .rd_en(b_rd_en), .dv(b_dv), .win_pos(b_win_pos),
      .win_first(b_first), .win_last(b_last), .pool_addr(b_pool),
      .busy(b_busy), .done(b_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      m_rd_addr = sel ? b_rd_addr : a_rd_addr;
      m_rd_en   = sel ? b_rd_en   : a_rd_en;
      m_dv      = sel ? b_dv      : a_dv;
      m_win_pos = sel ? b_win_pos : a_win_pos;
      m_first   = sel ? b_first   : a_first;
      m_last    = sel ? b_last    : a_last;
      m_pool    = sel ? b_pool    : a_pool;
      m_busy    = sel ? b_busy    : a_busy;
      m_done    = sel ? b_done    : a_done;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: element i of the pass is element (i%4) of window i/4, windows row-major
   function automatic int exp_addr(input int i, input int base);
      int w, p;
      w = i / 4;
      p = i % 4;
      return base + (2 * (w / 12) + p / 2) * 24 + 2 * (w % 12) + p % 2;
   endfunction

   // Ready: held high or toggled randomly, changed just after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: log issued addresses and returned tags of the selected instance
   always @(negedge clk) begin
      if (mon) begin
         if (!ready) chk("rd_en_while_ready_low", int'(m_rd_en), 0);
         if (m_rd_en) begin
            rd_addr_q.push_back(int'(m_rd_addr));
            rd_cyc_q.push_back(cyc - t0 + 1);
         end
         if (m_dv) begin
            dv_pos_q.push_back(int'(m_win_pos));
            dv_pool_q.push_back(int'(m_pool));
            dv_first_q.push_back(int'(m_first));
            dv_last_q.push_back(int'(m_last));
            dv_cyc_q.push_back(cyc - t0 + 1);
         end
      end
   end

   task automatic clear_logs();
      rd_addr_q.delete();
      rd_cyc_q.delete();
      dv_pos_q.delete();
      dv_pool_q.delete();
      dv_first_q.delete();
      dv_last_q.delete();
      dv_cyc_q.delete();
   endtask

   // Pulse start so it is sampled at edge 0; returns one ns into cycle 1
   task automatic start_pass();
      @(posedge clk);
      #1;
      if (sel) start_b = 1'b1;
      else     start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      t0  = cyc;
      mon = 1'b1;
      chk("done_low_after_accept", int'(m_done), 0);
      chk("busy_high_after_accept", int'(m_busy), 1);
   endtask

   task automatic do_pass(input bit rnd);
      bit got;
      got = 1'b0;
      clear_logs();
      rand_ready = rnd;
      start_pass();
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #2;
         if (m_done) begin
            got = 1'b1;
            break;
         end
      end
      done_cyc = cyc - t0 + 1;
      chk("done_within_budget", int'(got), 1);
      mon = 1'b0;
      rand_ready = 1'b0;
   endtask

   task automatic check_pass(input string tag, input int lat, input int base, input bit full);
      int nf, nl;
      nf = 0;
      nl = 0;
      chk({tag, " rd_en_count"}, rd_addr_q.size(), 576);
      chk({tag, " dv_count"}, dv_pos_q.size(), 576);
      for (int i = 0; i < rd_addr_q.size() && i < 576; i++)
         chk($sformatf("%s addr[%0d]", tag, i), rd_addr_q[i], exp_addr(i, base));
      for (int i = 0; i < dv_pos_q.size() && i < 576; i++) begin
         chk($sformatf("%s win_pos[%0d]", tag, i), dv_pos_q[i], i % 4);
         chk($sformatf("%s pool_addr[%0d]", tag, i), dv_pool_q[i], i / 4);
         chk($sformatf("%s win_first[%0d]", tag, i), dv_first_q[i], (i % 4 == 0) ? 1 : 0);
         chk($sformatf("%s win_last[%0d]", tag, i), dv_last_q[i], (i % 4 == 3) ? 1 : 0);
         if (i < rd_cyc_q.size())
            chk($sformatf("%s dv_latency[%0d]", tag, i), dv_cyc_q[i] - rd_cyc_q[i], lat);
         nf += dv_first_q[i];
         nl += dv_last_q[i];
      end
      chk({tag, " win_first_count"}, nf, 144);
      chk({tag, " win_last_count"}, nl, 144);
      if (dv_cyc_q.size() > 0)
         chk({tag, " done_after_last_dv"}, done_cyc, dv_cyc_q[dv_cyc_q.size()-1] + 1);
      if (full && rd_cyc_q.size() == 576) begin
         chk({tag, " first_rd_cycle"}, rd_cyc_q[0], 1);
         chk({tag, " last_rd_cycle"}, rd_cyc_q[575], 576);
         chk({tag, " done_cycle"}, done_cyc, 577 + lat);
      end
   endtask

   task automatic chk_zero_a(input string tag);
      chk({tag, " rd_addr"}, int'(a_rd_addr), 0);
      chk({tag, " rd_en"}, int'(a_rd_en), 0);
      chk({tag, " dv"}, int'(a_dv), 0);
      chk({tag, " win_pos"}, int'(a_win_pos), 0);
      chk({tag, " win_first"}, int'(a_first), 0);
      chk({tag, " win_last"}, int'(a_last), 0);
      chk({tag, " pool_addr"}, int'(a_pool), 0);
      chk({tag, " busy"}, int'(a_busy), 0);
      chk({tag, " done"}, int'(a_done), 0);
   endtask

   initial begin
      int n_rd, n_dv;
      tbl[0]  = '{0, 0, 0, 0};     tbl[1]  = '{1, 1, 1, 0};
      tbl[2]  = '{2, 24, 2, 0};    tbl[3]  = '{3, 25, 3, 0};
      tbl[4]  = '{4, 2, 0, 1};     tbl[5]  = '{5, 3, 1, 1};
      tbl[6]  = '{6, 26, 2, 1};    tbl[7]  = '{7, 27, 3, 1};
      tbl[8]  = '{48, 48, 0, 12};  tbl[9]  = '{49, 49, 1, 12};
      tbl[10] = '{50, 72, 2, 12};  tbl[11] = '{51, 73, 3, 12};
      tbl[12] = '{572, 550, 0, 143}; tbl[13] = '{573, 551, 1, 143};
      tbl[14] = '{574, 574, 2, 143}; tbl[15] = '{575, 575, 3, 143};

      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b1;
      sel = 1'b0; mon = 1'b0; rand_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero_a("reset_a");
      chk("reset_b rd_addr", int'(b_rd_addr), 0);
      chk("reset_b dv", int'(b_dv), 0);
      chk("reset_b busy", int'(b_busy), 0);
      chk("reset_b done", int'(b_done), 0);
      reset = 1'b0;

      // Full pass, ready held high, plus table of known addresses and tags
      sel = 1'b0;
      do_pass(1'b0);
      check_pass("a_full", 1, 0, 1'b1);
      for (int k = 0; k < 16; k++) begin
         if (tbl[k].idx < rd_addr_q.size())
            chk($sformatf("tbl addr[%0d]", tbl[k].idx), rd_addr_q[tbl[k].idx], tbl[k].addr);
         if (tbl[k].idx < dv_pos_q.size()) begin
            chk($sformatf("tbl pos[%0d]", tbl[k].idx), dv_pos_q[tbl[k].idx], tbl[k].pos);
            chk($sformatf("tbl pool[%0d]", tbl[k].idx), dv_pool_q[tbl[k].idx], tbl[k].pool);
         end
      end
      if (dv_cyc_q.size() > 0) chk("first_dv_cycle", dv_cyc_q[0], 2);

      // Restart from DONE: done drops on the accept edge, sequence repeats
      do_pass(1'b0);
      check_pass("a_again", 1, 0, 1'b1);

      // Random ready throttling
      do_pass(1'b1);
      check_pass("a_rand", 1, 0, 1'b0);

      // Longer latency with an offset base
      sel = 1'b1;
      do_pass(1'b0);
      check_pass("b_lat3", 3, 144, 1'b1);
      sel = 1'b0;

      // Stray start at cycle 100, reset at cycle 299, then clean restart
      clear_logs();
      start_pass();
      repeat (98) @(posedge clk);
      #1;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      chk("stray_start busy", int'(a_busy), 1);
      repeat (199) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk_zero_a("mid_reset");
      chk("mid rd_count", rd_addr_q.size(), 298);
      chk("mid dv_count", dv_pos_q.size(), 297);
      for (int i = 0; i < rd_addr_q.size(); i++)
         chk($sformatf("mid addr[%0d]", i), rd_addr_q[i], exp_addr(i, 0));
      for (int i = 0; i < dv_pool_q.size(); i++)
         chk($sformatf("mid pool[%0d]", i), dv_pool_q[i], i / 4);
      n_rd = rd_addr_q.size();
      n_dv = dv_pos_q.size();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("post_reset rd_count", rd_addr_q.size(), n_rd);
      chk("post_reset dv_count", dv_pos_q.size(), n_dv);
      chk("post_reset busy", int'(a_busy), 0);
      chk("post_reset done", int'(a_done), 0);
      mon = 1'b0;

      do_pass(1'b0);
      check_pass("a_restart", 1, 0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
